cpu_boot_ctrl: RTL and testbench
================================

Name: cpu_boot_ctrl

Overview:
- Boot and run sequencer for the single-cycle SoC.
- Accepts a program as a valid/ready word stream and writes it into instruction memory through that memory's write port. While loading, it holds the CPU core in reset.
- After loading, it releases the core, counts run cycles until ebreak, then halts. It can be restarted for a new program without a global reset.

Parameters:
- ADDR_WIDTH, 12, instruction memory word-address width.
- DATA_WIDTH, 32, instruction word width.
- RST_HOLD, 4, cycles core reset stays low after load completes (range 1..255).
- WDT_LIMIT, 32'd1000000, run-cycle limit used only by the optional watchdog.

Ports:
- clk_i  input  1  system clock.
- rstn_i  input  1  asynchronous, active-low reset.
- start_i  input  1  pulse: begin a load; honoured only in IDLE or HALT.
- ld_valid_i  input  1  load word valid.
- ld_data_i  input  DATA_WIDTH  load word.
- ld_last_i  input  1  marks final word of the program.
- ld_ready_o  output  1  controller accepts a word this cycle.
- insn_mem_wen_o  output  1  instruction memory write enable.
- insn_mem_waddr_o  output  ADDR_WIDTH  instruction memory write word address.
- insn_o  output  DATA_WIDTH  instruction memory write data.
- core_rstn_o  output  1  active-low reset to the CPU core.
- ebreak_i  input  1  ebreak from the core.
- busy_o  output  1  high in LOAD, HOLD or RUN.
- halted_o  output  1  high in HALT.
- overflow_o  output  1  sticky: load hit the top address without ld_last_i.
- timeout_o  output  1  sticky: watchdog expired (optional feature).
- run_cycles_o  output  32  core cycles executed in the last or current run.
- words_o  output  ADDR_WIDTH+1  words written in the last load.

Behaviour:
- Reset is asynchronous, active-low, on rstn_i. While it is low:
  - state=IDLE, all counters 0.
  - ld_ready_o=0, insn_mem_wen_o=0, insn_mem_waddr_o=0, insn_o=0, core_rstn_o=0.
  - busy_o=0, halted_o=0, overflow_o=0, timeout_o=0, run_cycles_o=0, words_o=0.
- Reset asserted mid-operation aborts at once. Partially written memory is left as is.
- All outputs are registered. Write interface: a word handshakes when ld_valid_i && ld_ready_o at a rising edge. The next cycle presents insn_mem_wen_o=1, insn_o=word, insn_mem_waddr_o=current address. This is one cycle of latency, for exactly one cycle per accepted word.
- States:
  - IDLE: core_rstn_o=0, ld_ready_o=0. On start_i go to LOAD, clear address, words_o, overflow_o, timeout_o and run_cycles_o.
  - LOAD: core_rstn_o=0, ld_ready_o=1. Each handshake writes the word and increments the address and words_o.
    - Handshake with ld_last_i=1: go to HOLD, ld_ready_o=0 from the next cycle.
    - Handshake at address 2^ADDR_WIDTH-1 without ld_last_i: the word is written, overflow_o is set, go to HOLD. The address does not wrap.
    - ld_valid_i low: stall indefinitely. start_i is ignored.
  - HOLD: core_rstn_o=0 for RST_HOLD cycles, counted from entering HOLD. The final write pulse of LOAD completes during the first HOLD cycle. Then go to RUN.
  - RUN: core_rstn_o=1. run_cycles_o increments every cycle, saturating at 32'hFFFFFFFF. If ebreak_i=1, go to HALT. The cycle with ebreak is counted.
  - HALT: core_rstn_o=0, halted_o=1. Counters are held. start_i goes to LOAD with the same clearing as IDLE.
- start_i in LOAD, HOLD or RUN is ignored.
- ebreak_i outside RUN is ignored.
- ebreak_i and watchdog expiry in the same cycle: ebreak wins, timeout_o stays 0.
- insn_mem_wen_o is never high outside the cycle after a LOAD handshake.

Optional Feature:
- Macro: BOOT_CTRL_WATCHDOG_EN.
- Defined: in RUN, when run_cycles_o reaches WDT_LIMIT (after the increment) and ebreak_i=0, set timeout_o and go to HALT.
- Undefined: no watchdog logic. timeout_o is tied to 0 and RUN ends only on ebreak_i or reset.

Test Plan:
- Reset then idle: hold rstn_i low 3 cycles and release, no start_i -> core_rstn_o=0, ld_ready_o=0, busy_o=0, insn_mem_wen_o never asserted.
- Basic load/run: start_i; stream 32'h00500093, 32'h00100073 (last) back-to-back ->
  - wen pulses at addresses 0 and 1 with those data;
  - words_o=2;
  - core_rstn_o rises exactly RST_HOLD cycles after the last handshake;
  - ebreak_i driven 10 cycles later -> halted_o=1, run_cycles_o=10 (core_rstn_o=1 through ebreak cycle).
- Backpressure gaps: ld_valid_i toggled 1,0,0,1,1(last) -> exactly 3 writes at addresses 0,1,2, no write in gap cycles.
- Overflow: ADDR_WIDTH=4, stream 17 words, never last ->
  - 16 writes at addresses 0..15;
  - overflow_o=1, enters HOLD after the 16th word;
  - 17th word not accepted (ld_ready_o=0).
- Restart and mid-op reset:
  - From HALT, start_i and load 1 word -> address restarts at 0, run_cycles_o cleared.
  - Assert rstn_i during RUN -> core_rstn_o=0 in the same cycle, state IDLE.
- Watchdog (with BOOT_CTRL_WATCHDOG_EN, WDT_LIMIT=20): run with no ebreak -> timeout_o=1, halted_o=1, run_cycles_o=20. Without the macro: still RUN at cycle 100.

Source files
------------

// File: rtl/cpu_boot_ctrl.sv
// Boot/run sequencer: streams a program into instruction memory, holds the core in reset,
// then runs it until ebreak. Optional watchdog enabled by defining BOOT_CTRL_WATCHDOG_EN.
module cpu_boot_ctrl #(
  parameter int unsigned ADDR_WIDTH = 12,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned RST_HOLD   = 4,
  parameter logic [31:0] WDT_LIMIT  = 32'd1000000
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  input  logic                  start_i,
  input  logic                  ld_valid_i,
  input  logic [DATA_WIDTH-1:0] ld_data_i,
  input  logic                  ld_last_i,
  output logic                  ld_ready_o,
  output logic                  insn_mem_wen_o,
  output logic [ADDR_WIDTH-1:0] insn_mem_waddr_o,
  output logic [DATA_WIDTH-1:0] insn_o,
  output logic                  core_rstn_o,
  input  logic                  ebreak_i,
  output logic                  busy_o,
  output logic                  halted_o,
  output logic                  overflow_o,
  output logic                  timeout_o,
  output logic [31:0]           run_cycles_o,
  output logic [ADDR_WIDTH:0]   words_o
);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_HOLD, S_RUN, S_HALT} state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [7:0]            hold_q, hold_d;
  logic [ADDR_WIDTH:0]   words_d;
  logic [31:0]           run_d, run_inc;
  logic [ADDR_WIDTH-1:0] waddr_d;
  logic [DATA_WIDTH-1:0] insn_d;
  logic                  wen_d, ovf_d, hs;
`ifdef BOOT_CTRL_WATCHDOG_EN
  logic                  tmo_d;
`endif

  assign hs      = ld_valid_i && ld_ready_o;
  assign run_inc = (run_cycles_o == '1) ? run_cycles_o : run_cycles_o + 32'd1;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    hold_d  = '0;
    words_d = words_o;
    run_d   = run_cycles_o;
    ovf_d   = overflow_o;
    wen_d   = 1'b0;
    waddr_d = insn_mem_waddr_o;
    insn_d  = insn_o;
`ifdef BOOT_CTRL_WATCHDOG_EN
    tmo_d   = timeout_o;
`endif
    unique case (state_q)
      S_IDLE, S_HALT: begin
        if (start_i) begin
          state_d = S_LOAD;
          addr_d  = '0;
          words_d = '0;
          run_d   = '0;
          ovf_d   = 1'b0;
`ifdef BOOT_CTRL_WATCHDOG_EN
          tmo_d   = 1'b0;
`endif
        end
      end
      S_LOAD: begin
        if (hs) begin
          wen_d   = 1'b1;
          waddr_d = addr_q;
          insn_d  = ld_data_i;
          words_d = words_o + 1'b1;
          // Address saturates at the top word; reaching it without last ends the load.
          if (addr_q != '1) addr_d = addr_q + 1'b1;
          if (ld_last_i) begin
            state_d = S_HOLD;
          end else if (addr_q == '1) begin
            ovf_d   = 1'b1;
            state_d = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        if (hold_q == 8'(RST_HOLD - 1)) state_d = S_RUN;
        else                            hold_d  = hold_q + 8'd1;
      end
      S_RUN: begin
        run_d = run_inc;
        if (ebreak_i) begin
          state_d = S_HALT;
        end
`ifdef BOOT_CTRL_WATCHDOG_EN
        else if (run_inc == WDT_LIMIT) begin
          tmo_d   = 1'b1;
          state_d = S_HALT;
        end
`endif
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q          <= S_IDLE;
      addr_q           <= '0;
      hold_q           <= '0;
      words_o          <= '0;
      run_cycles_o     <= '0;
      overflow_o       <= 1'b0;
      insn_mem_wen_o   <= 1'b0;
      insn_mem_waddr_o <= '0;
      insn_o           <= '0;
      ld_ready_o       <= 1'b0;
      core_rstn_o      <= 1'b0;
      busy_o           <= 1'b0;
      halted_o         <= 1'b0;
    end else begin
      state_q          <= state_d;
      addr_q           <= addr_d;
      hold_q           <= hold_d;
      words_o          <= words_d;
      run_cycles_o     <= run_d;
      overflow_o       <= ovf_d;
      insn_mem_wen_o   <= wen_d;
      insn_mem_waddr_o <= waddr_d;
      insn_o           <= insn_d;
      ld_ready_o       <= (state_d == S_LOAD);
      core_rstn_o      <= (state_d == S_RUN);
      busy_o           <= (state_d == S_LOAD) || (state_d == S_HOLD) || (state_d == S_RUN);
      halted_o         <= (state_d == S_HALT);
    end
  end

`ifdef BOOT_CTRL_WATCHDOG_EN
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) timeout_o <= 1'b0;
    else         timeout_o <= tmo_d;
  end
`else
  // Constant 0; the reference keeps WDT_LIMIT in use when the watchdog is compiled out.
  assign timeout_o = 1'b0 & (WDT_LIMIT != 32'd0);
`endif

endmodule

// File: tb/tb_cpu_boot_ctrl.sv
// Directed, table-driven bench for cpu_boot_ctrl (ADDR_WIDTH=4, RST_HOLD=3, WDT_LIMIT=20).
module tb_cpu_boot_ctrl;
  localparam int AW = 4;
  localparam int RH = 3;

  logic          clk = 1'b0;
  logic          rstn, start, ld_valid, ld_last, ebreak;
  logic [31:0]   ld_data;
  logic          ld_ready, wen, core_rstn, busy, halted, ovf, tmo;
  logic [AW-1:0] waddr;
  logic [31:0]   insn, run_cycles;
  logic [AW:0]   words;

  cpu_boot_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(32), .RST_HOLD(RH), .WDT_LIMIT(32'd20)) dut (
    .clk_i(clk), .rstn_i(rstn), .start_i(start), .ld_valid_i(ld_valid), .ld_data_i(ld_data),
    .ld_last_i(ld_last), .ld_ready_o(ld_ready), .insn_mem_wen_o(wen),
    .insn_mem_waddr_o(waddr), .insn_o(insn), .core_rstn_o(core_rstn), .ebreak_i(ebreak),
    .busy_o(busy), .halted_o(halted), .overflow_o(ovf), .timeout_o(tmo),
    .run_cycles_o(run_cycles), .words_o(words)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int wr_count = 0;
  int exp_addr = 0;

  always @(negedge clk) if (wen) wr_count++;

  typedef struct {
    int          nwords;
    logic [15:0] gapmask;
    int          run_len;
    logic [AW:0] exp_words;
    logic [31:0] exp_run;
    logic        exp_ovf;
  } vec_t;
  vec_t vecs[4];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    exp_addr = 0;
  endtask

  task automatic send_word(input logic [31:0] d, input logic last);
    bit ok = 1'b0;
    ld_valid = 1'b1;
    ld_data  = d;
    ld_last  = last;
    for (int k = 0; k < 20 && !ok; k++) begin
      ok = ld_ready;
      tick();
    end
    ld_valid = 1'b0;
    ld_last  = 1'b0;
    chk("handshake", ok, 1);
    chk("wen", wen, 1);
    chk("waddr", waddr, exp_addr[AW-1:0]);
    chk("wdata", insn, d);
    exp_addr++;
  endtask

  task automatic wait_run();
    bit ok = 1'b0;
    for (int k = 0; k < 20 && !ok; k++) begin
      tick();
      ok = core_rstn;
    end
    chk("core_release", ok, 1);
  endtask

  task automatic run_ebreak(input int n);
    repeat (n - 1) tick();
    ebreak = 1'b1;
    tick();
    ebreak = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "bench time limit");
  end

  initial begin
    int w0;
    bit done;
    vecs[0] = '{1,  16'h0000, 1, 5'd1,  32'd1, 1'b0};
    vecs[1] = '{3,  16'h0002, 5, 5'd3,  32'd5, 1'b0};
    vecs[2] = '{5,  16'h0015, 2, 5'd5,  32'd2, 1'b0};
    vecs[3] = '{16, 16'h0000, 7, 5'd16, 32'd7, 1'b0};

    rstn = 1'b0; start = 1'b0; ld_valid = 1'b0; ld_last = 1'b0; ebreak = 1'b0; ld_data = '0;

    // Reset then idle
    repeat (3) tick();
    chk("rst_core_rstn", core_rstn, 0);
    chk("rst_ready", ld_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_halted", halted, 0);
    chk("rst_words", words, 0);
    chk("rst_run", run_cycles, 0);
    chk("rst_insn", insn, 0);
    rstn = 1'b1;
    repeat (5) tick();
    chk("idle_ready", ld_ready, 0);
    chk("idle_busy", busy, 0);
    chk("idle_core_rstn", core_rstn, 0);
    chk("idle_writes", wr_count, 0);

    // Basic load/run with exact reset-hold timing
    pulse_start();
    chk("basic_ready", ld_ready, 1);
    chk("basic_busy", busy, 1);
    send_word(32'h00500093, 1'b0);
    send_word(32'h00100073, 1'b1);
    chk("basic_ready_off", ld_ready, 0);
    chk("basic_words", words, 2);
    for (int k = 1; k < RH; k++) begin
      tick();
      chk("basic_hold", core_rstn, 0);
      if (k == 1) chk("basic_wen_off", wen, 0);
    end
    tick();
    chk("basic_release", core_rstn, 1);
    repeat (9) tick();
    ebreak = 1'b1;
    chk("basic_core_at_ebreak", core_rstn, 1);
    tick();
    ebreak = 1'b0;
    chk("basic_halted", halted, 1);
    chk("basic_run", run_cycles, 10);
    chk("basic_core_halt", core_rstn, 0);
    chk("basic_writes", wr_count, 2);

    // Table-driven loads from HALT, with valid gaps
    foreach (vecs[v]) begin
      pulse_start();
      chk("vec_run_clr", run_cycles, 0);
      chk("vec_words_clr", words, 0);
      w0 = wr_count;
      for (int i = 0; i < vecs[v].nwords; i++) begin
        if (vecs[v].gapmask[i]) begin
          repeat (2) begin
            tick();
            chk("vec_gap_wen", wen, 0);
          end
        end
        send_word(32'hA5000000 | 32'(v << 8) | 32'(i), i == vecs[v].nwords - 1);
      end
      chk("vec_words", words, vecs[v].exp_words);
      chk("vec_ovf", ovf, vecs[v].exp_ovf);
      wait_run();
      run_ebreak(vecs[v].run_len);
      chk("vec_halted", halted, 1);
      chk("vec_run", run_cycles, vecs[v].exp_run);
      chk("vec_writes", wr_count - w0, vecs[v].nwords);
      chk("vec_busy", busy, 0);
    end

    // Overflow: 16 words without last, 17th refused; start/ebreak ignored in LOAD
    pulse_start();
    start = 1'b1; ebreak = 1'b1;
    tick();
    start = 1'b0; ebreak = 1'b0;
    chk("ld_ign_ready", ld_ready, 1);
    chk("ld_ign_halted", halted, 0);
    w0 = wr_count;
    for (int i = 0; i < 16; i++) send_word(32'h00001000 + 32'(i), 1'b0);
    chk("ovf_flag", ovf, 1);
    chk("ovf_ready", ld_ready, 0);
    chk("ovf_words", words, 16);
    chk("ovf_busy", busy, 1);
    ld_valid = 1'b1; ld_data = 32'hDEADBEEF;
    repeat (2) begin
      tick();
      chk("ovf_17_wen", wen, 0);
      chk("ovf_17_ready", ld_ready, 0);
    end
    ld_valid = 1'b0;
    chk("ovf_writes", wr_count - w0, 16);
    wait_run();
    run_ebreak(1);
    chk("ovf_run", run_cycles, 1);
    chk("ovf_sticky", ovf, 1);
    pulse_start();
    chk("ovf_clr", ovf, 0);

    // Start ignored in RUN, then mid-run reset
    send_word(32'h00000013, 1'b1);
    wait_run();
    repeat (3) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("run_start_ign_core", core_rstn, 1);
    chk("run_start_ign_ready", ld_ready, 0);
    #2 rstn = 1'b0;
    #1;
    chk("midrst_core", core_rstn, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_run", run_cycles, 0);
    chk("midrst_words", words, 0);
    tick();
    rstn = 1'b1;
    tick();
    chk("midrst_idle_ready", ld_ready, 0);
    chk("midrst_idle_busy", busy, 0);

    // Watchdog behaviour
    pulse_start();
    send_word(32'h00000013, 1'b1);
    wait_run();
`ifdef BOOT_CTRL_WATCHDOG_EN
    done = 1'b0;
    for (int k = 0; k < 40 && !done; k++) begin
      tick();
      done = halted;
    end
    chk("wdt_halted", done, 1);
    chk("wdt_timeout", tmo, 1);
    chk("wdt_run", run_cycles, 20);
    chk("wdt_core", core_rstn, 0);
    pulse_start();
    chk("wdt_tmo_clr", tmo, 0);
    send_word(32'h00000013, 1'b1);
    wait_run();
    run_ebreak(20);
    chk("wdt_tie_halted", halted, 1);
    chk("wdt_tie_timeout", tmo, 0);
    chk("wdt_tie_run", run_cycles, 20);
`else
    done = 1'b0;
    repeat (100) tick();
    chk("nowdt_run", run_cycles, 100);
    chk("nowdt_core", core_rstn, 1);
    chk("nowdt_busy", busy, 1);
    chk("nowdt_halted", halted, 0);
    chk("nowdt_timeout", tmo, 0);
    run_ebreak(1);
    chk("nowdt_end_halted", halted, 1);
    chk("nowdt_end_run", run_cycles, 101);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
